// File: rtl/lns_pkg.sv
// Shared definitions for the 16-bit LNS pipeline: word/register-select widths,
// result-select encodings and the halt sequencer state type.
package lns_pkg;

    localparam int LNS_WORD_W   = 16;
    localparam int LNS_REGSEL_W = 4;

    localparam logic [1:0] SEL_ALU   = 2'd0;
    localparam logic [1:0] SEL_IMM   = 2'd1;
    localparam logic [1:0] SEL_MEM   = 2'd2;
    localparam logic [1:0] SEL_SHIFT = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/lns_fwd_mux.sv
// Per-operand forwarding mux: stage-3 result beats the WB register, which beats
// the register file. No register is hardwired to zero.
module lns_fwd_mux
    import lns_pkg::*;
#(
    parameter int WIDTH    = LNS_WORD_W,
    parameter int REGSEL_W = LNS_REGSEL_W
) (
    input  logic [REGSEL_W-1:0] rd_addr,
    input  logic                s3_en,
    input  logic [REGSEL_W-1:0] s3_dest,
    input  logic [WIDTH-1:0]    s3_data,
    input  logic                wb_we,
    input  logic [REGSEL_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]    wb_data,
    input  logic [WIDTH-1:0]    rf_data,
    output logic [WIDTH-1:0]    fwd
);

    always_comb begin
        fwd = rf_data;
        if (s3_en && (s3_dest == rd_addr)) begin
            fwd = s3_data;
        end else if (wb_we && (wb_addr == rd_addr)) begin
            fwd = wb_data;
        end
    end

endmodule

// File: rtl/lns_wb_stage.sv
// LNS writeback stage: result select, WB register, operand forwarding and halt
// drain sequencing. Define LNS_WB_STATS_EN to add the retired/wr_count counters.
module lns_wb_stage
    import lns_pkg::*;
#(
    parameter int WIDTH        = LNS_WORD_W,
    parameter int REGSEL_W     = LNS_REGSEL_W,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_we,
    input  logic [REGSEL_W-1:0] in_dest,
    input  logic [1:0]          in_sel,
    input  logic [WIDTH-1:0]    in_alu,
    input  logic [WIDTH-1:0]    in_imm,
    input  logic [WIDTH-1:0]    in_mem,
    input  logic [WIDTH-1:0]    in_shift,
    input  logic                in_halt,
    input  logic [REGSEL_W-1:0] rd_s_addr,
    input  logic [REGSEL_W-1:0] rd_t_addr,
    input  logic [WIDTH-1:0]    rf_s,
    input  logic [WIDTH-1:0]    rf_t,
    output logic [WIDTH-1:0]    fwd_s,
    output logic [WIDTH-1:0]    fwd_t,
    output logic                rf_we,
    output logic [REGSEL_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]    rf_wdata,
    output logic                accept,
    output logic                halt
`ifdef LNS_WB_STATS_EN
    ,
    output logic [15:0]         retired,
    output logic [15:0]         wr_count
`endif
);

    localparam int                CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    halt_state_t         state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                halt_q;
    logic                capture;
    logic                s3_fwd_en;
    logic [WIDTH-1:0]    sel_data;

    logic                wb_valid;
    logic                wb_we;
    logic [REGSEL_W-1:0] wb_dest;
    logic [WIDTH-1:0]    wb_data;

    assign capture   = in_valid && accept;
    assign s3_fwd_en = capture && in_we && !in_halt;

    always_comb begin
        case (in_sel)
            SEL_ALU: sel_data = in_alu;
            SEL_IMM: sel_data = in_imm;
            SEL_MEM: sel_data = in_mem;
            default: sel_data = in_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (capture && in_halt) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            DRAIN: begin
                if (cnt == '0) state_nxt = HALTED;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        accept = (state == RUN);
    end

    // halt is registered off HALTED, giving DRAIN_CYCLES+1 cycles from capture.
    always_ff @(posedge clk) begin
        if (reset) halt_q <= 1'b0;
        else       halt_q <= halt_q || (state == HALTED);
    end
    assign halt = halt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else if (capture) begin
            wb_valid <= 1'b1;
            wb_we    <= in_we && !in_halt;
            wb_dest  <= in_dest;
            wb_data  <= sel_data;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    assign rf_we    = wb_valid && wb_we;
    assign rf_waddr = wb_dest;
    assign rf_wdata = wb_data;

    lns_fwd_mux #(.WIDTH(WIDTH), .REGSEL_W(REGSEL_W)) u_fwd_s (
        .rd_addr (rd_s_addr),
        .s3_en   (s3_fwd_en),
        .s3_dest (in_dest),
        .s3_data (sel_data),
        .wb_we   (rf_we),
        .wb_addr (rf_waddr),
        .wb_data (rf_wdata),
        .rf_data (rf_s),
        .fwd     (fwd_s)
    );

    lns_fwd_mux #(.WIDTH(WIDTH), .REGSEL_W(REGSEL_W)) u_fwd_t (
        .rd_addr (rd_t_addr),
        .s3_en   (s3_fwd_en),
        .s3_dest (in_dest),
        .s3_data (sel_data),
        .wb_we   (rf_we),
        .wb_addr (rf_waddr),
        .wb_data (rf_wdata),
        .rf_data (rf_t),
        .fwd     (fwd_t)
    );

`ifdef LNS_WB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired  <= '0;
            wr_count <= '0;
        end else begin
            if (capture) retired  <= retired + 16'd1;
            if (rf_we)   wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lns_wb_stage.sv
// Self-checking bench for lns_wb_stage; expected regfile writes go through a
// scoreboard queue and are popped when rf_we is observed.
module tb_lns_wb_stage;
    import lns_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_we, in_halt;
    logic [3:0]  in_dest, rd_s_addr, rd_t_addr;
    logic [1:0]  in_sel;
    logic [15:0] in_alu, in_imm, in_mem, in_shift, rf_s, rf_t;
    logic [15:0] fwd_s, fwd_t, rf_wdata;
    logic [3:0]  rf_waddr;
    logic        rf_we, accept, halt;
`ifdef LNS_WB_STATS_EN
    logic [15:0] retired, wr_count;
`endif

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    lns_wb_stage #(.WIDTH(16), .REGSEL_W(4), .DRAIN_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_we     (in_we),
        .in_dest   (in_dest),
        .in_sel    (in_sel),
        .in_alu    (in_alu),
        .in_imm    (in_imm),
        .in_mem    (in_mem),
        .in_shift  (in_shift),
        .in_halt   (in_halt),
        .rd_s_addr (rd_s_addr),
        .rd_t_addr (rd_t_addr),
        .rf_s      (rf_s),
        .rf_t      (rf_t),
        .fwd_s     (fwd_s),
        .fwd_t     (fwd_t),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .accept    (accept),
        .halt      (halt)
`ifdef LNS_WB_STATS_EN
        ,
        .retired   (retired),
        .wr_count  (wr_count)
`endif
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_we = 0; in_halt = 0; in_dest = 0; in_sel = SEL_ALU;
        in_alu = 0; in_imm = 0; in_mem = 0; in_shift = 0;
        rd_s_addr = 0; rd_t_addr = 0; rf_s = 0; rf_t = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({rf_we, rf_waddr, rf_wdata} !== 21'd0) begin
            fails++;
            $display("FAIL reset_wport: got we=%0b addr=%0d data=%h, want 0/0/0000", rf_we, rf_waddr, rf_wdata);
        end
        tests++;
        if (halt !== 1'b0 || accept !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctrl: got halt=%0b accept=%0b, want 0/1", halt, accept);
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        in_valid = 1; in_we = 1; in_dest = 4'd3; in_sel = SEL_ALU; in_alu = 16'h1234;
        exp_q.push_back(wr_t'{addr: 4'd3, data: 16'h1234});
        cycle();
        in_valid = 0;
        tests++;
        if (rf_we !== 1'b1 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL basic_we: got rf_we=%0b, want 1", rf_we);
        end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
                fails++;
                $display("FAIL basic_data: got r%0d=%h, want r%0d=%h", rf_waddr, rf_wdata, e.addr, e.data);
            end
        end
        cycle();
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL basic_we_clear: got rf_we=%0b, want 0", rf_we);
        end
    endtask

    task automatic test_sel_sweep();
        logic [15:0] exp_d;
        do_reset();
        in_alu = 16'h000A; in_imm = 16'hFFF8; in_mem = 16'hBEEF; in_shift = 16'h0F0F;
        for (int s = 0; s < 4; s++) begin
            in_valid = 1; in_we = 1; in_dest = 4'd5; in_sel = 2'(s);
            case (s)
                0: exp_d = 16'h000A;
                1: exp_d = 16'hFFF8;
                2: exp_d = 16'hBEEF;
                default: exp_d = 16'h0F0F;
            endcase
            exp_q.push_back(wr_t'{addr: 4'd5, data: exp_d});
            cycle();
            tests++;
            if (rf_we !== 1'b1 || exp_q.size() == 0) begin
                fails++;
                $display("FAIL sel_we[%0d]: got rf_we=%0b, want 1", s, rf_we);
            end else begin
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
                    fails++;
                    $display("FAIL sel_data[%0d]: got r%0d=%h, want r%0d=%h", s, rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
        in_valid = 0;
        cycle();
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL sel_idle: got rf_we=%0b, want 0", rf_we);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        in_valid = 1; in_we = 1; in_dest = 4'd2; in_sel = SEL_ALU; in_alu = 16'h0055;
        exp_q.push_back(wr_t'{addr: 4'd2, data: 16'h0055});
        cycle();
        tests++;
        if (rf_we !== 1'b1 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL fwd_wb_we: got rf_we=%0b, want 1", rf_we);
        end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
                fails++;
                $display("FAIL fwd_wb_data: got r%0d=%h, want r%0d=%h", rf_waddr, rf_wdata, e.addr, e.data);
            end
        end
        in_alu = 16'h00AA; rd_s_addr = 4'd2; rd_t_addr = 4'd2; rf_s = 16'h1111; rf_t = 16'h2222;
        #1;
        tests++;
        if (fwd_s !== 16'h00AA || fwd_t !== 16'h00AA) begin
            fails++;
            $display("FAIL fwd_s3: got s=%h t=%h, want 00aa/00aa", fwd_s, fwd_t);
        end
        in_valid = 0;
        #1;
        tests++;
        if (fwd_s !== 16'h0055 || fwd_t !== 16'h0055) begin
            fails++;
            $display("FAIL fwd_wb: got s=%h t=%h, want 0055/0055", fwd_s, fwd_t);
        end
        rd_s_addr = 4'd9; rf_s = 16'h0007;
        #1;
        tests++;
        if (fwd_s !== 16'h0007 || fwd_t !== 16'h0055) begin
            fails++;
            $display("FAIL fwd_rf: got s=%h t=%h, want 0007/0055", fwd_s, fwd_t);
        end
        in_valid = 1; in_dest = 4'd0; in_alu = 16'h0C0C; rd_s_addr = 4'd0;
        #1;
        tests++;
        if (fwd_s !== 16'h0C0C) begin
            fails++;
            $display("FAIL fwd_r0: got s=%h, want 0c0c", fwd_s);
        end
        exp_q.push_back(wr_t'{addr: 4'd0, data: 16'h0C0C});
        cycle();
        in_valid = 0;
        tests++;
        if (rf_we !== 1'b1 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL fwd_r0_we: got rf_we=%0b, want 1", rf_we);
        end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
                fails++;
                $display("FAIL fwd_r0_data: got r%0d=%h, want r%0d=%h", rf_waddr, rf_wdata, e.addr, e.data);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        in_valid = 1; in_we = 1; in_halt = 1; in_dest = 4'd6; in_alu = 16'hDEAD;
        cycle();
        tests++;
        if (rf_we !== 1'b0 || accept !== 1'b0 || halt !== 1'b0) begin
            fails++;
            $display("FAIL halt_n: got we=%0b accept=%0b halt=%0b, want 0/0/0", rf_we, accept, halt);
        end
        in_halt = 0; in_dest = 4'd4; in_alu = 16'h4444; rd_s_addr = 4'd4; rf_s = 16'h2222;
        #1;
        tests++;
        if (fwd_s !== 16'h2222) begin
            fails++;
            $display("FAIL halt_fwd_ignored: got s=%h, want 2222", fwd_s);
        end
        cycle();
        tests++;
        if (rf_we !== 1'b0 || halt !== 1'b0) begin
            fails++;
            $display("FAIL halt_n1: got we=%0b halt=%0b, want 0/0", rf_we, halt);
        end
        in_halt = 1;
        cycle();
        tests++;
        if (halt !== 1'b0 || rf_we !== 1'b0) begin
            fails++;
            $display("FAIL halt_n2: got halt=%0b we=%0b, want 0/0", halt, rf_we);
        end
        in_valid = 0; in_halt = 0;
        cycle();
        tests++;
        if (halt !== 1'b1 || accept !== 1'b0) begin
            fails++;
            $display("FAIL halt_n3: got halt=%0b accept=%0b, want 1/0", halt, accept);
        end
        in_valid = 1; in_we = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests++;
            if (halt !== 1'b1 || rf_we !== 1'b0 || accept !== 1'b0) begin
                fails++;
                $display("FAIL halt_sticky[%0d]: got halt=%0b we=%0b accept=%0b, want 1/0/0", i, halt, rf_we, accept);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        tests++;
        if (halt !== 1'b0 || accept !== 1'b1) begin
            fails++;
            $display("FAIL reset_from_halted: got halt=%0b accept=%0b, want 0/1", halt, accept);
        end
        in_valid = 1; in_halt = 1;
        cycle();
        in_valid = 0; in_halt = 0;
        reset = 1;
        cycle();
        reset = 0;
        tests++;
        if (halt !== 1'b0 || accept !== 1'b1 || rf_we !== 1'b0) begin
            fails++;
            $display("FAIL drain_reset: got halt=%0b accept=%0b we=%0b, want 0/1/0", halt, accept, rf_we);
        end
        in_valid = 1; in_we = 1; in_dest = 4'd1; in_sel = SEL_MEM; in_mem = 16'h0101;
        exp_q.push_back(wr_t'{addr: 4'd1, data: 16'h0101});
        cycle();
        in_valid = 0;
        tests++;
        if (rf_we !== 1'b1 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL drain_fresh_we: got rf_we=%0b, want 1", rf_we);
        end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
                fails++;
                $display("FAIL drain_fresh_data: got r%0d=%h, want r%0d=%h", rf_waddr, rf_wdata, e.addr, e.data);
            end
        end
        repeat (4) cycle();
        tests++;
        if (halt !== 1'b0 || accept !== 1'b1) begin
            fails++;
            $display("FAIL drain_no_stale: got halt=%0b accept=%0b, want 0/1", halt, accept);
        end
    endtask

`ifdef LNS_WB_STATS_EN
    task automatic test_stats();
        do_reset();
        in_valid = 1; in_we = 1; in_dest = 4'd7; in_sel = SEL_ALU; in_alu = 16'h7777;
        repeat (65535) @(posedge clk);
        #1;
        tests++;
        if (retired !== 16'hFFFF || wr_count !== 16'hFFFE) begin
            fails++;
            $display("FAIL stats_preload: got retired=%h wr_count=%h, want ffff/fffe", retired, wr_count);
        end
        in_we = 0;
        cycle();
        in_valid = 0;
        tests++;
        if (retired !== 16'h0000 || wr_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_wrap: got retired=%h wr_count=%h, want 0000/ffff", retired, wr_count);
        end
        cycle();
        tests++;
        if (retired !== 16'h0000 || wr_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_hold: got retired=%h wr_count=%h, want 0000/ffff", retired, wr_count);
        end
    endtask
`endif

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_basic_write();
        test_sel_sweep();
        test_forwarding();
        test_halt();
        test_reset_mid_drain();
`ifdef LNS_WB_STATS_EN
        test_stats();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending writes, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lns_wb_stage.md
Name: lns_wb_stage

Overview:
- Writeback stage directly downstream of execute/memory (stage 3) in the 16-bit LNS pipeline.
- Selects the retiring result from ALU, DMEM, immediate or shifter and registers it for one cycle. Drives the register-file write port.
- Forwards in-flight results to stage-2 operand reads.
- Sequences processor halt: drains the pipeline after a halt instruction retires, then asserts the sticky `halt`.

Parameters:
- WIDTH, 16, datapath word width
- REGSEL_W, 4, register-select width (16 registers)
- DRAIN_CYCLES, 2, cycles waited after halt capture before `halt` asserts

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  stage-3 result valid this cycle
- in_we  in  1  instruction writes a register
- in_dest  in  REGSEL_W  destination register
- in_sel  in  2  result select: 0 ALU, 1 immediate, 2 DMEM, 3 shifter
- in_alu  in  WIDTH  ALU result
- in_imm  in  WIDTH  sign-extended i8
- in_mem  in  WIDTH  DMEM read data
- in_shift  in  WIDTH  shifter result
- in_halt  in  1  instruction is a halt
- rd_s_addr  in  REGSEL_W  stage-2 S read address
- rd_t_addr  in  REGSEL_W  stage-2 T read address
- rf_s  in  WIDTH  regfile S read data
- rf_t  in  WIDTH  regfile T read data
- fwd_s  out  WIDTH  forwarded S operand
- fwd_t  out  WIDTH  forwarded T operand
- rf_we  out  1  regfile write enable
- rf_waddr  out  REGSEL_W  regfile write address
- rf_wdata  out  WIDTH  regfile write data
- accept  out  1  stage accepts new results (low once halt captured)
- halt  out  1  processor halted, sticky

Behaviour:
- Reset state:
  - WB register is invalid.
  - rf_we=0, rf_waddr=0, rf_wdata=0, halt=0, accept=1.
  - FSM is in RUN, drain counter=0.
  - Reset takes effect at any point, including mid-drain or while HALTED.
- Result mux (combinational on stage-3 inputs): sel_data = in_sel 0:in_alu, 1:in_imm, 2:in_mem, 3:in_shift.
- Capture: on posedge clk with in_valid && accept, the WB register loads:
  - valid=1
  - we = in_we && !in_halt
  - dest = in_dest
  - data = sel_data
- If the capture condition is false, WB valid clears to 0 on that edge.
- Write port:
  - rf_we = WB.valid && WB.we.
  - rf_waddr and rf_wdata come from the WB register.
  - Latency from stage-3 valid to regfile write is 1 cycle (registered).
- Forwarding (combinational, computed separately for S and T), priority from youngest to oldest:
  1. Stage-3 bypass: if in_valid && accept && in_we && !in_halt && in_dest==rd_x_addr, forward sel_data.
  2. Else WB bypass: if rf_we && rf_waddr==rd_x_addr, forward rf_wdata.
  3. Else forward rf_s / rf_t.
  - No register is hardwired to zero; r0 forwards like any other register.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN: accept=1. On a capture with in_halt=1, go to DRAIN and load counter=DRAIN_CYCLES-1. The halt instruction causes no regfile write.
  - DRAIN: accept=0, so new stage-3 results are ignored. Counter decrements each cycle. At counter==0, go to HALTED.
  - HALTED: accept=0, halt=1, rf_we=0. Stays here until reset.
  - DRAIN_CYCLES=1 means DRAIN lasts exactly one cycle.
  - Total halt latency is DRAIN_CYCLES+1 cycles after the halt capture edge.
- Simultaneous events:
  - in_halt together with in_we: the write is suppressed.
  - A second halt arriving during DRAIN is ignored.
- Widths: all data paths are WIDTH bits. No arithmetic is performed except the drain counter, which is $clog2(DRAIN_CYCLES+1) bits wide.

Optional Feature:
- Macro: LNS_WB_STATS_EN.
- Defined:
  - Adds output `retired` (16 bits): count of captures with in_valid && accept, halt included. Wraps 16'hFFFF→0.
  - Adds output `wr_count` (16 bits): count of cycles with rf_we=1. Wraps the same way.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `lns_pkg`:
  - WORD/REGSEL widths
  - result-select encodings (SEL_ALU=0, SEL_IMM=1, SEL_MEM=2, SEL_SHIFT=3)
  - halt FSM state typedef (RUN, DRAIN, HALTED)
- One sub-module: `lns_fwd_mux`, the per-operand 3-way priority forwarding mux. It is instantiated twice, once for S and once for T.

Test Plan:
1. Reset, then in_valid=1, in_we=1, in_dest=3, in_sel=0, in_alu=16'h1234 → next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234. Following cycle rf_we=0.
2. in_sel sweep with in_alu=A, in_imm=FFF8, in_mem=BEEF, in_shift=0F0F on dest 5 → rf_wdata matches the selected source on each retire.
3. Forwarding:
   - Stage 3 writes r2=16'h00AA while WB holds r2=16'h0055 and rd_s_addr=rd_t_addr=2 → fwd_s=fwd_t=00AA.
   - Stage 3 invalid instead → 0055.
   - No match, with rf_s=7 → fwd_s=7.
4. Halt with DRAIN_CYCLES=2:
   - in_halt=1, in_we=1 captured at edge N → no write; accept=0 from N.
   - A valid write to r4 at N+1 is ignored.
   - halt=1 from edge N+3 and stays high.
5. Reset asserted during DRAIN → next cycle halt=0, accept=1, rf_we=0; a fresh write to r1 retires normally.
6. With LNS_WB_STATS_EN: preload retired=16'hFFFF via 65535 retires, one more retire → retired=0; wr_count equals the number of rf_we cycles.
